axi_lite_slave_mem: RTL

//  Parametrised AXI4-Lite memory slave. Successor of the single-FSM bus slave.

---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/axi_lite_slave_mem_if.sv | 39 +++
 rtl/byte_strobe_mem.sv | 44 ++++
 rtl/axi_lite_slave_mem.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite memory slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between an interconnect master port and the memory slave.
interface axi_lite_slave_mem_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  M_AWVALID;
  logic [ADDR_W-1:0]     M_AWADDR;
  logic                  S_AWREADY;
  logic                  M_WVALID;
  logic [DATA_W-1:0]     M_WDATA;
  logic [DATA_W/8-1:0]   M_WSTRB;
  logic                  S_WREADY;
  logic                  S_BVALID;
  logic [1:0]            S_BRESP;
  logic                  M_BREADY;
  logic                  M_ARVALID;
  logic [ADDR_W-1:0]     M_ARADDR;
  logic                  S_ARREADY;
  logic                  S_RVALID;
  logic [DATA_W-1:0]     S_RDATA;
  logic [1:0]            S_RRESP;
  logic                  M_RREADY;

  modport slave (
    input  M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    input  M_ARVALID, M_ARADDR, M_RREADY,
    output S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
    output S_ARREADY, S_RVALID, S_RDATA, S_RRESP
  );

  modport master (
    output M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    output M_ARVALID, M_ARADDR, M_RREADY,
    input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
    input  S_ARREADY, S_RVALID, S_RDATA, S_RRESP
  );

endinterface

// File: rtl/byte_strobe_mem.sv
// Word-organised storage array with per-byte write enables and a registered read port.
module byte_strobe_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned StrbW = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IdxW-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [StrbW-1:0]  wstrb_i,
  input  logic              re_i,
  input  logic [IdxW-1:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Non-blocking read of the same edge as a write yields the pre-write word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite scratch memory slave: independent write (AW/W/B) and read (AR/R) FSMs,
// byte strobes, and SLVERR for addresses beyond the array.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic                  S_ACLK,
  input  logic                  S_ARRESET_N,
  axi_lite_slave_mem_if.slave   bus
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(StrbW);
  localparam int unsigned Depth = MEM_BYTES / StrbW;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_BYTES);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IdxW'(addr >> LaneW);
  endfunction

  // Reset asserts asynchronously but releases two edges later, in step with S_ACLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
    if (!S_ARRESET_N) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------- Write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              awready, wready, bvalid;
  logic              aw_hs, w_hs, b_hs, commit, mem_we;
  logic [ADDR_W-1:0] cur_awaddr;
  logic [DATA_W-1:0] cur_wdata;
  logic [StrbW-1:0]  cur_wstrb;

  always_ff @(posedge S_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready = rst_n & ~aw_held_q;
        wready  = rst_n & ~w_held_q;
      end
      W_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  assign aw_hs      = bus.M_AWVALID & awready;
  assign w_hs       = bus.M_WVALID & wready;
  assign b_hs       = bvalid & bus.M_BREADY;
  assign cur_awaddr = aw_hs ? bus.M_AWADDR : awaddr_q;
  assign cur_wdata  = w_hs ? bus.M_WDATA : wdata_q;
  assign cur_wstrb  = w_hs ? bus.M_WSTRB : wstrb_q;
  // Commit on the edge where the later of AW/W lands (or both together).
  assign commit     = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign mem_we     = commit & in_range(cur_awaddr);

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = bus.M_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = bus.M_WDATA;
      wstrb_d  = bus.M_WSTRB;
    end
    unique case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          bresp_d   = in_range(cur_awaddr) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- Read path ----------------
  r_state_e    r_state_q, r_state_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        arready, rvalid, ar_hs;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge S_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state_q)
      R_IDLE:  arready = rst_n;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign ar_hs = bus.M_ARVALID & arready;

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rresp_d   = in_range(bus.M_ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (bus.M_RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  byte_strobe_mem #(
    .DEPTH  (Depth),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (S_ACLK),
    .rst_ni  (rst_n),
    .we_i    (mem_we),
    .waddr_i (word_idx(cur_awaddr)),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_wstrb),
    .re_i    (ar_hs),
    .raddr_i (word_idx(bus.M_ARADDR)),
    .rdata_o (mem_rdata)
  );

  assign bus.S_AWREADY = awready;
  assign bus.S_WREADY  = wready;
  assign bus.S_BVALID  = bvalid;
  assign bus.S_BRESP   = bresp_q;
  assign bus.S_ARREADY = arready;
  assign bus.S_RVALID  = rvalid;
  // Out-of-range reads return zero regardless of what the array port last latched.
  assign bus.S_RDATA   = (rresp_q == RESP_OKAY) ? mem_rdata : '0;
  assign bus.S_RRESP   = rresp_q;

endmodule
